sub_operand_sequencer: RTL
==========================

# sub_operand_sequencer

- Sequential front/back end for the 8-bit ripple-borrow subtractor.
- Collects operands A then B from one shared 8-bit byte stream using a valid/ready handshake.
- Presents A and B to a `subtractor_8bits` instance, registers its 9-bit result, and adds a magnitude output and a delivered-result counter.
- Returns the result downstream through a second valid/ready handshake.

## Interface
Parameters:
- `CNT_W`, default 8: width of the delivered-result counter.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `clear`, input, 1: synchronous abort; returns the block to WAIT_A.
- `in_data`, input, 8: operand byte; the first accepted byte is A, the second is B.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block accepts a byte this cycle.
- `diff`, output, 8: (A − B) mod 256, registered.
- `borrow`, output, 1: 1 when A < B (bit 8 of the subtractor result), registered.
- `mag`, output, 8: |A − B|, registered.
- `out_valid`, output, 1: the result outputs are valid.
- `out_ready`, input, 1: downstream accepts the result.
- `res_count`, output, CNT_W: number of results delivered, wraps modulo 2^CNT_W.

## Operation
- FSM states: WAIT_A, WAIT_B, CALC, RESULT.
- WAIT_A
  - `in_ready` = 1.
  - On `in_valid`&`in_ready`: capture `in_data` into `a_reg` and go to WAIT_B.
- WAIT_B
  - `in_ready` = 1.
  - On handshake: capture `in_data` into `b_reg` and go to CALC.
- CALC
  - `in_ready` = 0.
  - Register the subtractor outputs: `diff` = s[7:0] and `borrow` = s[8].
  - `mag` = borrow ? (~s[7:0] + 1) mod 256 : s[7:0]. This always fits in 8 bits.
  - Go to RESULT.
- RESULT
  - `out_valid` = 1 and `in_ready` = 0.
  - `diff`, `borrow` and `mag` hold stable until the handshake completes.
  - On `out_ready`: increment `res_count` and go to WAIT_A.
- `out_valid` is asserted only in RESULT. `in_ready` is asserted only in WAIT_A and WAIT_B. Input and output handshakes therefore never coincide.
- `clear` has priority over every handshake:
  - Next state is WAIT_A and `out_valid` drops.
  - A byte presented in the same cycle is not captured.
  - A result being handshaken in the same cycle is not counted.
  - `res_count` and the result registers keep their values.
- `res_count` wraps from 2^CNT_W − 1 to 0.
- `out_ready` is ignored outside RESULT. `in_valid` is ignored while `in_ready` = 0.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state = WAIT_A, so `in_ready` = 1 once `rst_n` deasserts.
  - `a_reg`, `b_reg`, `diff`, `mag`, `res_count` = 0.
  - `borrow` = 0, `out_valid` = 0.
- Reset mid-operation discards any captured operand or pending result without a handshake.
- Latency:
  - B accepted at edge k puts the FSM in CALC.
  - Edge k+1 registers the result; `out_valid` is high from edge k+1.
  - Best-case throughput is one result per 4 cycles: A, B, CALC, RESULT with `out_ready` = 1.
- Backpressure: RESULT persists indefinitely while `out_ready` = 0, with all outputs held.
- The subtractor path is combinational from `a_reg`/`b_reg`. It must settle within one clock: an 8-stage ripple.

## Structure
- Shared package `sub_pkg` holds:
  - state encoding (2-bit localparams WAIT_A=0, WAIT_B=1, CALC=2, RESULT=3);
  - `DATA_W` = 8;
  - `RES_W` = 9.
- One sub-module: the existing `subtractor_8bits`, instantiated unchanged as the datapath (a→`a_reg`, b→`b_reg`, s→9-bit wire).
- FSM, operand registers, result registers, magnitude logic and counter live in this module.

## Test plan
- A=0x50, B=0x30, `out_ready`=1 → diff=0x20, borrow=0, mag=0x20; `out_valid` high exactly one cycle; `res_count` 0→1.
- A=0x30, B=0x50 → diff=0xE0, borrow=1, mag=0x20.
- A=0x00, B=0xFF, then A=0xFF, B=0xFF → diff=0x01, borrow=1, mag=0xFF; then diff=0x00, borrow=0, mag=0x00.
- Backpressure: `out_ready`=0 for 5 cycles in RESULT → outputs stable, `in_ready`=0, `res_count` unchanged; counts once `out_ready` rises.
- `clear` asserted in WAIT_B with `in_valid`=1 → byte not captured; next bytes 0x10, 0x01 yield diff=0x0F.
- `rst_n` pulsed low in RESULT → `out_valid`=0 and `res_count`=0 immediately; `in_ready`=1 after release. Then force `res_count` wrap (CNT_W=2, 4 results) → count returns to 0.

Source files
------------

// File: rtl/sub_pkg.sv
// sub_pkg: shared widths and FSM state encoding for the operand sequencer
package sub_pkg;
  localparam int DATA_W = 8;
  localparam int RES_W = 9;
  localparam logic [1:0] WAIT_A = 2'd0;
  localparam logic [1:0] WAIT_B = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] RESULT = 2'd3;
endpackage

// File: rtl/subtractor_8bits.sv
// subtractor_8bits: ripple-borrow subtractor, s[7:0] = a - b, s[8] = final borrow
module subtractor_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] s
);
  logic [8:0] br;
  assign br[0] = 1'b0;
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s[i] = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end
  assign s[8] = br[8];
endmodule

// File: rtl/sub_operand_sequencer.sv
// sub_operand_sequencer: collects A then B from a byte stream, subtracts, returns diff/borrow/mag
module sub_operand_sequencer
  import sub_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] diff,
  output logic              borrow,
  output logic [DATA_W-1:0] mag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  res_count
);
  logic [1:0] state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q, diff_q, mag_q, mag_d;
  logic borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RES_W-1:0] s;
  logic in_hs, out_hs;

  subtractor_8bits u_sub (
    .a(a_q),
    .b(b_q),
    .s(s)
  );

  // clear masks both handshakes so nothing is captured or counted in that cycle
  assign in_hs = in_valid & in_ready & ~clear;
  assign out_hs = out_valid & out_ready & ~clear;
  assign mag_d = s[8] ? ~s[DATA_W-1:0] + DATA_W'(1) : s[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_A;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) state_d = WAIT_A;
    else if (state_q == WAIT_A && in_hs) state_d = WAIT_B;
    else if (state_q == WAIT_B && in_hs) state_d = CALC;
    else if (state_q == CALC) state_d = RESULT;
    else if (state_q == RESULT && out_hs) state_d = WAIT_A;
  end

  always_comb begin
    in_ready = (state_q == WAIT_A) || (state_q == WAIT_B);
    out_valid = state_q == RESULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      borrow_q <= 1'b0;
      mag_q <= '0;
      cnt_q <= '0;
    end else begin
      if (in_hs && state_q == WAIT_A) a_q <= in_data;
      if (in_hs && state_q == WAIT_B) b_q <= in_data;
      if (state_q == CALC && !clear) begin
        diff_q <= s[DATA_W-1:0];
        borrow_q <= s[DATA_W];
        mag_q <= mag_d;
      end
      if (out_hs) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign diff = diff_q;
  assign borrow = borrow_q;
  assign mag = mag_q;
  assign res_count = cnt_q;
endmodule
